counter_ctrl_seq: RTL and testbench
===================================

# counter_ctrl_seq

Command sequencer that drives the control side of the up/down loadable counter: it accepts LOAD/UP/DOWN/SEEK commands over a valid/ready port, buffers them, and converts each one into the exact `load_n`/`ce`/`up_down`/`data_load` cycle pattern. It reads back `count_out`, `zero` and `max_count` from the counter. It sits between a host or test controller and the counter instance, and is the stimulus end of the interface that the counter assertions observe.

## Interface
- `WIDTH`, 4: counter width; also the width of command arguments.
- `DEPTH`, 4: command FIFO depth (power of two, ≥2).
- `clk` input 1: single clock; all logic is posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: FIFO not full; a command is accepted when `cmd_valid && cmd_ready`.
- `cmd_op` input 2: 00 LOAD, 01 UP, 10 DOWN, 11 SEEK.
- `cmd_arg` input WIDTH: load value, step count, or seek target.
- `load_n` output 1: counter load, active-low.
- `ce` output 1: counter enable.
- `up_down` output 1: 1 = up, 0 = down.
- `data_load` output WIDTH: load value.
- `count_out` input WIDTH: counter value.
- `zero` input 1: counter flag.
- `max_count` input 1: counter flag.
- `busy` output 1: FSM not in IDLE, or FIFO not empty.
- `done` output 1: one-cycle pulse when a command completes.
- `err` output 1: sticky readback error (see Configuration).

## Operation
- FSM states: IDLE, LOAD, STEP, DONE.
- IDLE:
  - If the FIFO is non-empty, pop the head and latch op/arg.
  - LOAD goes to LOAD.
  - UP/DOWN with arg≠0 go to STEP with `remaining`=arg.
  - SEEK computes `remaining` = |arg − shadow| and the direction from shadow (up if arg > shadow), then goes to STEP if `remaining`≠0.
  - Zero-step commands go straight to DONE.
- LOAD: `load_n`=0 and `data_load`=arg for exactly one cycle; shadow←arg; next state DONE.
- STEP:
  - `ce`=1 with `up_down` per op.
  - Each cycle: `remaining`−1; shadow±1 modulo 2^WIDTH.
  - Exit to DONE on the cycle where `remaining`==1.
- DONE: `done`=1 for one cycle; readback check (if enabled); next state IDLE.
- Shadow register: the block's model of the counter value; reset value 0, matching the counter reset.
- UP/DOWN wrap modulo 2^WIDTH. SEEK never wraps; it always takes the direct path.
- Outside LOAD, `load_n`=1 and `data_load` holds its last value. Outside STEP, `ce`=0.
- FIFO push and pop in the same cycle are both allowed. When full, `cmd_ready`=0 and any offered command is ignored.

## Timing
- Reset values: `load_n`=1, `ce`=0, `up_down`=1, `data_load`=0, `done`=0, `err`=0, `busy`=0, `cmd_ready`=1, FSM=IDLE, FIFO empty, shadow=0.
- Control outputs are registered. The counter samples them at the next edge, so `count_out` reflects a LOAD or a final step in the DONE cycle.
- Per-command cycle cost:
  - LOAD: 3 cycles (IDLE + LOAD + DONE).
  - UP/DOWN n: n+2 cycles.
  - SEEK: |Δ|+2 cycles.
  - Zero-step command: 2 cycles.
- A command accepted while the FIFO is empty and the FSM is in IDLE is popped on the following cycle (1-cycle accept-to-dispatch latency).
- Back-to-back commands have no bubble beyond IDLE.
- Reset asserted mid-command: all outputs return to reset values immediately (asynchronously), the FIFO is flushed, and no `done` is emitted.

## Configuration
- `COUNTER_CTRL_CHECK_EN` defined: in DONE, `err` is set if any of the following holds:
  - `count_out` ≠ shadow;
  - `zero` ≠ (`count_out`==0);
  - `max_count` ≠ (`count_out`=='1).
  
  `err` stays set until reset.
- Not defined: `err` is tied to 0, and no compare logic is built.

## Structure
- `counter_ctrl_pkg` contains:
  - the `cmd_op_t` enum (LOAD/UP/DOWN/SEEK);
  - the `state_t` enum;
  - the op encoding constants.
- Sub-module `counter_ctrl_fifo`: synchronous FIFO, parameters WIDTH+2 and DEPTH, with push/pop/full/empty and an asynchronous active-low reset.

## Test plan
- LOAD 9 → `load_n` low for exactly 1 cycle with `data_load`=9; `done` follows on the next cycle with `count_out`=9.
- LOAD 14, then UP 3 → `ce`=1 and `up_down`=1 for 3 consecutive cycles; count goes 15, 0, 1; `done` with `count_out`=1; `err`=0.
- LOAD 2, SEEK 7 → 5 up-steps, then `done` at 7. Then SEEK 7 again → no `ce` cycles, `done` 2 cycles after dispatch.
- Push 4 commands while executing DOWN 10 → `cmd_ready`=0 once full; a 5th valid command is dropped; the 4 queued commands execute in order.
- Assert `rst_n` low after 4 steps of UP 10 → `ce`=0, `busy`=0, FIFO empty, no `done`; after release, `cmd_ready`=1.
- With `COUNTER_CTRL_CHECK_EN` defined, hold `count_out` at 5 against an expected value of 6 → `err` rises in DONE and stays 1 until reset.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared op encodings, command and FSM state types for the counter sequencer.
package counter_ctrl_pkg;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_SEEK = 2'b11;
  typedef enum logic [1:0] {
    CMD_LOAD = OP_LOAD,
    CMD_UP   = OP_UP,
    CMD_DOWN = OP_DOWN,
    CMD_SEEK = OP_SEEK
  } cmd_op_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STEP, S_DONE} state_t;
endpackage

// File: rtl/counter_ctrl_fifo.sv
// counter_ctrl_fifo: synchronous command FIFO; pushes while full and pops while empty are ignored.
module counter_ctrl_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout = mem[rd_ptr[AW-1:0]];
  // storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  // pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
endmodule

// File: rtl/counter_ctrl_seq.sv
// counter_ctrl_seq: buffers LOAD/UP/DOWN/SEEK commands and replays them as counter load/enable cycles.
// Readback checking in DONE is built only when COUNTER_CTRL_CHECK_EN is defined.
module counter_ctrl_seq #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic             load_n,
  output logic             ce,
  output logic             up_down,
  output logic [WIDTH-1:0] data_load,
  input  logic [WIDTH-1:0] count_out,
  input  logic             zero,
  input  logic             max_count,
  output logic             busy,
  output logic             done,
  output logic             err
);
  import counter_ctrl_pkg::*;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  state_t state, state_nxt;
  logic [WIDTH+1:0] head;
  cmd_op_t head_op;
  logic [WIDTH-1:0] head_arg, shadow, remaining, seek_dist, step_cnt;
  logic full, empty, pop, seek_up, step_up;
  assign head_op = cmd_op_t'(head[WIDTH+1:WIDTH]);
  assign head_arg = head[WIDTH-1:0];
  assign cmd_ready = !full;
  assign busy = state != S_IDLE || !empty;
  counter_ctrl_fifo #(.WIDTH(WIDTH + 2), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .pop   (pop),
    .din   ({cmd_op, cmd_arg}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nxt;
  // decode the FIFO head and choose the next state; SEEK takes the direct path, never wrapping
  always_comb begin
    state_nxt = state;
    pop = 1'b0;
    seek_up = head_arg > shadow;
    seek_dist = seek_up ? head_arg - shadow : shadow - head_arg;
    step_cnt = head_op == CMD_SEEK ? seek_dist : head_arg;
    step_up = head_op == CMD_SEEK ? seek_up : head_op == CMD_UP;
    case (state)
      S_IDLE: if (!empty) begin
        pop = 1'b1;
        state_nxt = head_op == CMD_LOAD ? S_LOAD : step_cnt != '0 ? S_STEP : S_DONE;
      end
      S_LOAD: state_nxt = S_DONE;
      S_STEP: state_nxt = remaining == ONE ? S_DONE : S_STEP;
      default: state_nxt = S_IDLE;
    endcase
  end
  // registered counter controls, step bookkeeping and the shadow copy of the counter value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      load_n <= 1'b1;
      ce <= 1'b0;
      up_down <= 1'b1;
      data_load <= '0;
      done <= 1'b0;
      shadow <= '0;
      remaining <= '0;
    end else begin
      load_n <= state_nxt != S_LOAD;
      ce <= state_nxt == S_STEP;
      done <= state_nxt == S_DONE;
      if (pop) remaining <= step_cnt;
      if (pop && state_nxt == S_STEP) up_down <= step_up;
      if (pop && state_nxt == S_LOAD) data_load <= head_arg;
      if (state == S_LOAD) shadow <= data_load;
      else if (state == S_STEP) begin
        shadow <= up_down ? shadow + ONE : shadow - ONE;
        remaining <= remaining - ONE;
      end
    end
`ifdef COUNTER_CTRL_CHECK_EN
  logic mismatch;
  assign mismatch = count_out != shadow || zero != (count_out == '0) || max_count != (count_out == '1);
  // sticky readback error, evaluated when a command completes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err <= 1'b0;
    else if (state == S_DONE && mismatch) err <= 1'b1;
`else
  logic unused_readback;
  assign unused_readback = ^{count_out, zero, max_count};
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_counter_ctrl_seq.sv
// tb_counter_ctrl_seq: directed tests of the sequencer against a behavioural up/down loadable counter.
module tb_counter_ctrl_seq;
  import counter_ctrl_pkg::*;
  localparam int W = 4;
  logic clk = 1'b0, rst_n = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [W-1:0] cmd_arg = '0;
  logic load_n, ce, up_down, zero, max_count, busy, done, err;
  logic [W-1:0] data_load, count_out, cnt;
  logic hold = 1'b0;
  int passed = 0, total = 0;
  int cyc = 0, ce_cnt = 0, up_cnt = 0, done_cnt = 0;
  int done_cyc_h [64];
  logic [W-1:0] done_val_h [64];
  always #5 clk = ~clk;
  counter_ctrl_seq #(.WIDTH(W), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .load_n    (load_n),
    .ce        (ce),
    .up_down   (up_down),
    .data_load (data_load),
    .count_out (count_out),
    .zero      (zero),
    .max_count (max_count),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );
  // behavioural counter the sequencer drives; hold forces a stuck readback value of 5
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (!load_n) cnt <= data_load;
    else if (ce) cnt <= up_down ? cnt + 4'd1 : cnt - 4'd1;
  assign count_out = hold ? 4'd5 : cnt;
  assign zero = count_out == '0;
  assign max_count = count_out == '1;
  // cycle monitor: counts steps and records every done pulse
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ce) ce_cnt <= ce_cnt + 1;
    if (ce && up_down) up_cnt <= up_cnt + 1;
    if (done && done_cnt < 64) begin
      done_cyc_h[done_cnt] <= cyc;
      done_val_h[done_cnt] <= count_out;
      done_cnt <= done_cnt + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic send(input logic [1:0] op, input logic [W-1:0] arg);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_arg = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_dones(input int target, input int limit);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
    @(negedge clk);
  endtask
  initial begin
    int bce, bup, bd, n;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_load_n", load_n, 1);
    chk("rst_ce", ce, 0);
    chk("rst_up_down", up_down, 1);
    chk("rst_data_load", data_load, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    // LOAD 9: one load cycle, then done with the new count
    send(OP_LOAD, 4'd9);
    chk("ld9_queued_busy", busy, 1);
    chk("ld9_pre_load_n", load_n, 1);
    @(negedge clk);
    chk("ld9_load_n", load_n, 0);
    chk("ld9_data_load", data_load, 9);
    @(negedge clk);
    chk("ld9_load_n_after", load_n, 1);
    chk("ld9_done", done, 1);
    chk("ld9_count", count_out, 9);
    @(negedge clk);
    chk("ld9_done_pulse", done, 0);
    chk("ld9_idle", busy, 0);
    // LOAD 14 then UP 3 wraps through 15, 0, 1
    bce = ce_cnt; bup = up_cnt; bd = done_cnt;
    send(OP_LOAD, 4'd14);
    send(OP_UP, 4'd3);
    wait_dones(bd + 2, 40);
    chk("up3_ce_cycles", ce_cnt - bce, 3);
    chk("up3_up_cycles", up_cnt - bup, 3);
    chk("ld14_val", done_val_h[bd], 14);
    chk("up3_val", done_val_h[bd + 1], 1);
    chk("up3_spacing", done_cyc_h[bd + 1] - done_cyc_h[bd], 5);
    chk("up3_err", err, 0);
    // LOAD 2, SEEK 7 (5 up-steps), SEEK 7 again (zero steps, 2 cycles)
    bce = ce_cnt; bup = up_cnt; bd = done_cnt;
    send(OP_LOAD, 4'd2);
    send(OP_SEEK, 4'd7);
    send(OP_SEEK, 4'd7);
    wait_dones(bd + 3, 60);
    chk("seek_ce_cycles", ce_cnt - bce, 5);
    chk("seek_up_cycles", up_cnt - bup, 5);
    chk("seek_val", done_val_h[bd + 1], 7);
    chk("seek_spacing", done_cyc_h[bd + 1] - done_cyc_h[bd], 7);
    chk("seek0_val", done_val_h[bd + 2], 7);
    chk("seek0_spacing", done_cyc_h[bd + 2] - done_cyc_h[bd + 1], 2);
    // DOWN 10 running while the FIFO fills; a fifth command is dropped
    bce = ce_cnt; bup = up_cnt; bd = done_cnt;
    send(OP_DOWN, 4'd10);
    send(OP_LOAD, 4'd3);
    send(OP_UP, 4'd2);
    send(OP_SEEK, 4'd1);
    send(OP_DOWN, 4'd1);
    chk("full_ready", cmd_ready, 0);
    chk("full_busy", busy, 1);
    cmd_valid = 1'b1; cmd_op = OP_UP; cmd_arg = 4'd5;
    repeat (3) @(negedge clk);
    chk("full_ready_held", cmd_ready, 0);
    cmd_valid = 1'b0;
    wait_dones(bd + 5, 120);
    repeat (10) @(negedge clk);
    chk("fifo_done_total", done_cnt - bd, 5);
    chk("down10_val", done_val_h[bd], 13);
    chk("q_load3_val", done_val_h[bd + 1], 3);
    chk("q_up2_val", done_val_h[bd + 2], 5);
    chk("q_seek1_val", done_val_h[bd + 3], 1);
    chk("q_down1_val", done_val_h[bd + 4], 0);
    chk("fifo_ce_cycles", ce_cnt - bce, 17);
    chk("fifo_up_cycles", up_cnt - bup, 2);
    chk("fifo_idle", busy, 0);
    chk("fifo_ready_back", cmd_ready, 1);
    // reset in the middle of UP 10 with a command still queued
    bce = ce_cnt; bd = done_cnt;
    send(OP_UP, 4'd10);
    send(OP_LOAD, 4'd5);
    n = 0;
    while (ce_cnt < bce + 4 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (ce_cnt < bce + 4) chk("step_wait", ce_cnt, bce + 4);
    @(negedge clk);
    chk("mid_ce_active", ce, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ce", ce, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_done", done, 0);
    chk("arst_up_down", up_down, 1);
    chk("arst_data_load", data_load, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("arst_no_done", done_cnt - bd, 0);
    chk("arst_flushed", busy, 0);
    chk("arst_ready_after", cmd_ready, 1);
    chk("arst_count", count_out, 0);
    // stuck readback: counter reports 5 while the shadow expects 6
    bd = done_cnt;
    hold = 1'b1;
    send(OP_LOAD, 4'd6);
    chk("chk_err_before", err, 0);
    wait_dones(bd + 1, 20);
    hold = 1'b0;
`ifdef COUNTER_CTRL_CHECK_EN
    chk("chk_err_set", err, 1);
`else
    chk("chk_err_tied", err, 0);
`endif
    send(OP_LOAD, 4'd0);
    wait_dones(bd + 2, 20);
`ifdef COUNTER_CTRL_CHECK_EN
    chk("chk_err_sticky", err, 1);
`else
    chk("chk_err_tied2", err, 0);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("chk_err_cleared", err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
